// File: rtl/tb_uart.sv
// 8N1 UART receive monitor: oversamples ser_rx with the system clock, recovers
// bytes, flags framing errors and end-of-line (0x0A) characters.
module tb_uart #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       line_done,
  output logic       busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, rxs_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        line_done_q, line_done_d;
  logic        busy_q, busy_d;
  logic        half_hit, full_hit;

  assign half_hit = (cnt_q == HALF_M1);
  assign full_hit = (cnt_q == FULL_M1);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= ser_rx;
      rxs_q   <= sync1_q;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!rxs_q) state_d = START;
      START:     if (half_hit) state_d = rxs_q ? IDLE : DATA;
      DATA:      if (full_hit && bit_cnt_q == 3'd7) state_d = STOP;
      STOP:      if (full_hit) state_d = rxs_q ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    line_done_d = 1'b0;
    busy_d      = (state_d != IDLE);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    // Counter restarts on every state change and at each data-bit sample.
    if (state_d != state_q || state_q == IDLE || state_q == WAIT_HIGH || full_hit)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 16'd1;
    if (state_q == IDLE)
      bit_cnt_d = '0;
    if (state_q == DATA && full_hit) begin
      shift_d   = {rxs_q, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if (state_q == STOP && full_hit) begin
      if (rxs_q) begin
        rx_data_d   = shift_q;
        rx_valid_d  = 1'b1;
        line_done_d = (shift_q == 8'h0A);
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      line_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      line_done_q <= line_done_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign line_done = line_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tb_uart.sv
// Bench for tb_uart: drives 8N1 frames and compares recorded output pulses
// against an expected-event list derived from the frames sent.
module tb_tb_uart;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       ser_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, line_done, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cycles = 0;

  typedef struct {
    bit       rv;
    bit       fe;
    bit       ld;
    bit [7:0] data;
    int       cyc;
  } ev_t;

  ev_t evq[$];
  ev_t expq[$];

  tb_uart #(.CLKS_PER_BIT(C)) dut (
    .clock    (clk),
    .resetb   (resetb),
    .ser_rx   (ser_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .line_done(line_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (busy) busy_cycles++;
    if (rx_valid || frame_err || line_done) begin
      e.rv = rx_valid; e.fe = frame_err; e.ld = line_done;
      e.data = rx_data; e.cyc = cyc;
      evq.push_back(e);
    end
  end

  // All drivers assume they start at a rising edge and end at one.
  task automatic idle(input int n);
    #1 ser_rx = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, output int t0);
    #1 ser_rx = 1'b0;
    t0 = cyc + 1;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 ser_rx = b[i];
      repeat (C) @(posedge clk);
    end
    if (stop_low > 0) begin
      #1 ser_rx = 1'b0;
      repeat (C * stop_low) @(posedge clk);
      #1 ser_rx = 1'b1;
    end else begin
      #1 ser_rx = 1'b1;
      repeat (C) @(posedge clk);
    end
  endtask

  task automatic compare_events(input string tag, input logic [7:0] final_data);
    checks++;
    if (evq.size() != expq.size()) begin
      errors++;
      $display("FAIL %s event count: got %0d expected %0d", tag, evq.size(), expq.size());
    end else begin
      for (int i = 0; i < expq.size(); i++) begin
        checks++;
        if (evq[i].rv !== expq[i].rv || evq[i].fe !== expq[i].fe ||
            evq[i].ld !== expq[i].ld || evq[i].data !== expq[i].data) begin
          errors++;
          $display("FAIL %s event %0d: got rv=%0b fe=%0b ld=%0b data=%02h expected rv=%0b fe=%0b ld=%0b data=%02h",
                   tag, i, evq[i].rv, evq[i].fe, evq[i].ld, evq[i].data,
                   expq[i].rv, expq[i].fe, expq[i].ld, expq[i].data);
        end
      end
    end
    checks++;
    if (rx_data !== final_data) begin
      errors++;
      $display("FAIL %s final rx_data: got %02h expected %02h", tag, rx_data, final_data);
    end
  endtask

  function automatic ev_t good(input logic [7:0] b);
    ev_t e;
    e.rv = 1'b1; e.fe = 1'b0; e.ld = (b == 8'h0A); e.data = b; e.cyc = 0;
    return e;
  endfunction

  function automatic ev_t bad(input logic [7:0] held);
    ev_t e;
    e.rv = 1'b0; e.fe = 1'b1; e.ld = 1'b0; e.data = held; e.cyc = 0;
    return e;
  endfunction

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_data, rx_valid, frame_err, line_done, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset outputs: got data=%02h rv=%0b fe=%0b ld=%0b busy=%0b expected all 0",
               rx_data, rx_valid, frame_err, line_done, busy);
    end
    resetb = 1'b1;
    @(posedge clk);
    busy_cycles = 0;
    evq.delete();
    idle(1000);
    checks++;
    if (evq.size() != 0 || busy_cycles != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d pulses, %0d busy cycles expected 0, 0", evq.size(), busy_cycles);
    end
  endtask

  task automatic test_single();
    int t0;
    evq.delete(); expq.delete();
    send_frame(8'h41, 0, t0);
    idle(4);
    expq.push_back(good(8'h41));
    compare_events("single_0x41", 8'h41);
    if (evq.size() == 1) begin
      int lat = evq[0].cyc - t0;
      int req = 2 + C / 2 + 9 * C;
      checks++;
      if (lat < req - 1 || lat > req + 1) begin
        errors++;
        $display("FAIL latency: got %0d clocks expected %0d +-1", lat, req);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [7:0] s [3];
    s[0] = 8'h41; s[1] = 8'h42; s[2] = 8'h0A;
    evq.delete(); expq.delete();
    for (int i = 0; i < 3; i++) begin
      send_frame(s[i], 0, t0);
      expq.push_back(good(s[i]));
    end
    idle(4);
    compare_events("back_to_back_AB_nl", 8'h0A);
  endtask

  task automatic test_frame_err();
    int t0;
    evq.delete(); expq.delete();
    send_frame(8'h55, 3, t0);
    expq.push_back(bad(8'h0A));
    idle(2 * C);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_break: got %0b expected 0", busy);
    end
    send_frame(8'h12, 0, t0);
    expq.push_back(good(8'h12));
    idle(4);
    compare_events("frame_err_then_0x12", 8'h12);
  endtask

  task automatic test_glitch();
    evq.delete(); expq.delete();
    busy_cycles = 0;
    #1 ser_rx = 1'b0;
    repeat (C / 4) @(posedge clk);
    idle(3 * C);
    compare_events("glitch", 8'h12);
    checks++;
    if (busy !== 1'b0 || busy_cycles == 0 || busy_cycles > C) begin
      errors++;
      $display("FAIL glitch_busy: got busy=%0b busy_cycles=%0d expected 0 and 1..%0d", busy, busy_cycles, C);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    logic [7:0] b;
    b = 8'hDE;
    evq.delete(); expq.delete();
    #1 ser_rx = 1'b0;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 ser_rx = b[i];
      repeat (C) @(posedge clk);
    end
    #1 ser_rx = b[4];
    repeat (C / 2) @(posedge clk);
    #1 resetb = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%0b data=%02h expected 0 00", busy, rx_data);
    end
    ser_rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 resetb = 1'b1;
    repeat (2 * C) @(posedge clk);
    send_frame(8'hDE, 0, t0);
    expq.push_back(good(8'hDE));
    idle(4);
    compare_events("reset_mid_then_0xDE", 8'hDE);
  endtask

  task automatic test_random();
    int t0;
    logic [7:0] last;
    last = 8'hDE;
    evq.delete(); expq.delete();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int stop_low, gap;
      b = 8'($urandom_range(0, 255));
      if (n % 5 == 0) b = 8'h0A;
      stop_low = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_frame(b, stop_low, t0);
      if (stop_low == 0) begin
        last = b;
        expq.push_back(good(b));
        gap = int'($urandom_range(0, 2)) * C;
      end else begin
        expq.push_back(bad(last));
        gap = int'($urandom_range(1, 2)) * C;
      end
      if (gap > 0) idle(gap);
    end
    idle(4);
    compare_events("random_stream", last);
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_random();
      end
      begin
        repeat (60000) @(posedge clk);
        errors++;
        $display("FAIL timeout: got no completion expected completion within 60000 clocks");
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
